// File: rtl/s100_bus_pkg.sv
// s100_bus_pkg
// Shared definitions for the S-100 I/O port responder:
//   resp_state_t   - responder FSM states
//   BUS_*_IDLE     - idle levels of the S-100 control/status inputs, used
//                    to preset the synchronizers so reset never looks like
//                    a bus edge
//   PRDY_READY     - PRDY level meaning "no wait state requested"
package s100_bus_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM_OUT  = 3'd1,
    WAIT_OUT = 3'd2,
    WRITE    = 3'd3,
    HOLD_OUT = 3'd4,
    ARM_IN   = 3'd5,
    WAIT_IN  = 3'd6,
    READ     = 3'd7
  } resp_state_t;

  localparam logic BUS_PSYNC_IDLE = 1'b0;
  localparam logic BUS_PDBIN_IDLE = 1'b0;
  localparam logic BUS_N_PWR_IDLE = 1'b1;
  localparam logic BUS_STAT_IDLE  = 1'b0;

  localparam logic PRDY_READY = 1'b1;

endpackage

// File: rtl/s100_sync.sv
// s100_sync
// Multi-flop synchronizer for asynchronous bus inputs plus one extra
// delayed copy of the last stage, so callers can detect edges by comparing
// q_o (newest synced value) with dly_o (one clock older).
//   clk_i  - fabric clock
//   rst_i  - synchronous active-high reset, loads RESET_VAL everywhere
//   d_i    - raw asynchronous input
//   q_o    - last synchronizer stage
//   dly_o  - q_o delayed by one clock
module s100_sync #(
  parameter int                 WIDTH     = 1,
  parameter int                 STAGES    = 2,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] dly_o
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] dly_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= RESET_VAL;
      dly_q <= RESET_VAL;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      dly_q <= stage_q[STAGES-1];
    end
  end

  assign q_o   = stage_q[STAGES-1];
  assign dly_o = dly_q;

endmodule

// File: rtl/s100_io_port_responder.sv
// s100_io_port_responder
// S-100 bus slave decoding a single 8-bit I/O port. OUT cycles latch the
// Data OUT byte into port_out_data; IN cycles return port_in_data on
// Data IN. Optional wait states are inserted through PRDY.
// Ports:
//   pll0_50MHz, reset          - fabric clock, sync active-high reset
//   s100_adr/DO/pSYNC/pDBIN/
//   n_pWR/sOUT/sINP            - asynchronous S-100 master signals
//   s100_DI, s100_DI_oe        - Data IN value and buffer enable
//   s100_PRDY                  - low while wait states are inserted
//   port_out_data/strobe       - written byte, one-clock pulse per write
//   port_in_data/strobe        - byte to return, one-clock pulse per read
//   dbg_state                  - current FSM state, for observation only
//
// Bus protocol as seen by this slave: a cycle starts with a pSYNC rising
// edge qualified by address and status; an OUT completes when n_pWR falls
// (data is taken while n_pWR is low) and the cycle ends once n_pWR returns
// high; an IN starts driving on the pDBIN rising edge and stops when pDBIN
// falls. PRDY low asks the master to stretch the strobe. A new pSYNC edge
// always wins over whatever cycle is in progress.
module s100_io_port_responder
  import s100_bus_pkg::*;
#(
  parameter logic [7:0] PORT_ADDR   = 8'h01,
  parameter int         WAIT_CYCLES = 0,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        pll0_50MHz,
  input  logic        reset,
  input  logic [15:0] s100_adr,
  input  logic [7:0]  s100_DO,
  input  logic        s100_pSYNC,
  input  logic        s100_pDBIN,
  input  logic        s100_n_pWR,
  input  logic        s100_sOUT,
  input  logic        s100_sINP,
  output logic [7:0]  s100_DI,
  output logic        s100_DI_oe,
  output logic        s100_PRDY,
  output logic [7:0]  port_out_data,
  output logic        port_out_strobe,
  input  logic [7:0]  port_in_data,
  output logic        port_in_strobe,
  output logic [2:0]  dbg_state
);

  localparam logic [7:0] WAIT_LD  = WAIT_CYCLES[7:0];
  localparam bit         HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [4:0] CTL_IDLE = {BUS_STAT_IDLE, BUS_STAT_IDLE,
                                     BUS_N_PWR_IDLE, BUS_PDBIN_IDLE,
                                     BUS_PSYNC_IDLE};

  // Control bit order: {sINP, sOUT, n_pWR, pDBIN, pSYNC}
  logic [4:0]  ctl_now, ctl_lvl;
  logic [15:0] ad_now, ad_lvl;

  s100_sync #(.WIDTH(5), .STAGES(SYNC_STAGES), .RESET_VAL(CTL_IDLE)) u_ctl_sync (
    .clk_i (pll0_50MHz),
    .rst_i (reset),
    .d_i   ({s100_sINP, s100_sOUT, s100_n_pWR, s100_pDBIN, s100_pSYNC}),
    .q_o   (ctl_now),
    .dly_o (ctl_lvl)
  );

  s100_sync #(.WIDTH(16), .STAGES(SYNC_STAGES), .RESET_VAL(16'h0000)) u_ad_sync (
    .clk_i (pll0_50MHz),
    .rst_i (reset),
    .d_i   ({s100_adr[7:0], s100_DO}),
    .q_o   (ad_now),
    .dly_o (ad_lvl)
  );

  // Only A7:A0 are decoded; the upper address byte is deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{s100_adr[15:8], ctl_now[4:3], ad_now};

  // Edge pulses are registered, and the FSM reads the delayed (ctl_lvl /
  // ad_lvl) copies so that every level it sees lines up with the pulse.
  logic psync_rise_q, pdbin_rise_q, npwr_fall_q;

  wire       psync_lvl = ctl_lvl[0];
  wire       pdbin_lvl = ctl_lvl[1];
  wire       npwr_lvl  = ctl_lvl[2];
  wire       sout_lvl  = ctl_lvl[3];
  wire       sinp_lvl  = ctl_lvl[4];
  wire [7:0] adr_lvl   = ad_lvl[15:8];
  wire [7:0] do_lvl    = ad_lvl[7:0];

  wire addr_hit = (adr_lvl == PORT_ADDR);
  wire hit_out  = addr_hit & sout_lvl & ~sinp_lvl;
  wire hit_in   = addr_hit & sinp_lvl & ~sout_lvl;

  resp_state_t state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  di_q, di_d;
  logic        di_oe_q, di_oe_d;
  logic        prdy_q, prdy_d;
  logic [7:0]  out_q, out_d;
  logic        out_stb_q, out_stb_d;
  logic        in_stb_q, in_stb_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    di_d      = di_q;
    di_oe_d   = di_oe_q;
    prdy_d    = prdy_q;
    out_d     = out_q;
    out_stb_d = 1'b0;
    in_stb_d  = 1'b0;

    if (psync_rise_q) begin
      // New cycle: abandon anything in flight and decode from scratch.
      di_oe_d = 1'b0;
      prdy_d  = PRDY_READY;
      cnt_d   = 8'd0;
      if (hit_out)     state_d = ARM_OUT;
      else if (hit_in) state_d = ARM_IN;
      else             state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: ;
        ARM_OUT: if (npwr_fall_q) begin
          if (HAS_WAIT) begin
            state_d = WAIT_OUT;
            prdy_d  = 1'b0;
            cnt_d   = WAIT_LD;
          end else begin
            state_d = WRITE;
          end
        end
        WAIT_OUT: begin
          if (cnt_q <= 8'd1) begin
            state_d = WRITE;
            prdy_d  = PRDY_READY;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        WRITE: begin
          out_d     = do_lvl;
          out_stb_d = 1'b1;
          state_d   = HOLD_OUT;
        end
        HOLD_OUT: if (npwr_lvl) state_d = IDLE;
        ARM_IN: if (pdbin_rise_q) begin
          // DI is captured exactly once here and then frozen for the cycle.
          di_d    = port_in_data;
          di_oe_d = 1'b1;
          if (HAS_WAIT) begin
            state_d = WAIT_IN;
            prdy_d  = 1'b0;
            cnt_d   = WAIT_LD;
          end else begin
            state_d = READ;
          end
        end
        WAIT_IN: begin
          if (cnt_q <= 8'd1) begin
            state_d = READ;
            prdy_d  = PRDY_READY;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        READ: if (!pdbin_lvl) begin
          di_oe_d  = 1'b0;
          in_stb_d = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge pll0_50MHz) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      di_q         <= 8'h00;
      di_oe_q      <= 1'b0;
      prdy_q       <= PRDY_READY;
      out_q        <= 8'h00;
      out_stb_q    <= 1'b0;
      in_stb_q     <= 1'b0;
      psync_rise_q <= 1'b0;
      pdbin_rise_q <= 1'b0;
      npwr_fall_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      di_q         <= di_d;
      di_oe_q      <= di_oe_d;
      prdy_q       <= prdy_d;
      out_q        <= out_d;
      out_stb_q    <= out_stb_d;
      in_stb_q     <= in_stb_d;
      psync_rise_q <= ctl_now[0] & ~psync_lvl;
      pdbin_rise_q <= ctl_now[1] & ~pdbin_lvl;
      npwr_fall_q  <= ~ctl_now[2] & npwr_lvl;
    end
  end

  assign s100_DI         = di_q;
  assign s100_DI_oe      = di_oe_q;
  assign s100_PRDY       = prdy_q;
  assign port_out_data   = out_q;
  assign port_out_strobe = out_stb_q;
  assign port_in_strobe  = in_stb_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_s100_io_port_responder.sv
// tb_s100_io_port_responder
// Two responders on one shared bus: instance 0 without wait states,
// instance 1 with three. Drivers issue S-100 cycles and push expected
// write/read bytes into per-instance queues; a monitor pops and compares
// on every strobe and checks DI stability while DI_oe is high.
module tb_s100_io_port_responder;

  localparam logic [7:0] PORT = 8'h01;
  localparam int         W1   = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] s100_adr = 16'h0000;
  logic [7:0]  s100_DO = 8'h00;
  logic        s100_pSYNC = 1'b0;
  logic        s100_pDBIN = 1'b0;
  logic        s100_n_pWR = 1'b1;
  logic        s100_sOUT = 1'b0;
  logic        s100_sINP = 1'b0;
  logic [7:0]  port_in_data = 8'h00;

  logic [7:0] di [2];
  logic       di_oe [2];
  logic       prdy [2];
  logic [7:0] pod [2];
  logic       out_stb [2];
  logic       in_stb [2];
  logic [2:0] dbg [2];

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  s100_io_port_responder #(.PORT_ADDR(PORT), .WAIT_CYCLES(0), .SYNC_STAGES(2)) dut0 (
    .pll0_50MHz(clk), .reset(reset), .s100_adr(s100_adr), .s100_DO(s100_DO),
    .s100_pSYNC(s100_pSYNC), .s100_pDBIN(s100_pDBIN), .s100_n_pWR(s100_n_pWR),
    .s100_sOUT(s100_sOUT), .s100_sINP(s100_sINP), .s100_DI(di[0]),
    .s100_DI_oe(di_oe[0]), .s100_PRDY(prdy[0]), .port_out_data(pod[0]),
    .port_out_strobe(out_stb[0]), .port_in_data(port_in_data),
    .port_in_strobe(in_stb[0]), .dbg_state(dbg[0])
  );

  s100_io_port_responder #(.PORT_ADDR(PORT), .WAIT_CYCLES(W1), .SYNC_STAGES(2)) dut1 (
    .pll0_50MHz(clk), .reset(reset), .s100_adr(s100_adr), .s100_DO(s100_DO),
    .s100_pSYNC(s100_pSYNC), .s100_pDBIN(s100_pDBIN), .s100_n_pWR(s100_n_pWR),
    .s100_sOUT(s100_sOUT), .s100_sINP(s100_sINP), .s100_DI(di[1]),
    .s100_DI_oe(di_oe[1]), .s100_PRDY(prdy[1]), .port_out_data(pod[1]),
    .port_out_strobe(out_stb[1]), .port_in_data(port_in_data),
    .port_in_strobe(in_stb[1]), .dbg_state(dbg[1])
  );

  // Scoreboard state
  logic [7:0] exp_out_q0[$], exp_out_q1[$], exp_in_q0[$], exp_in_q1[$];
  logic [7:0] exp_di = 8'h00;
  logic [7:0] model_out = 8'h00;
  int checks = 0;
  int errors = 0;

  // Written by the monitor only
  int last_wr_cyc [2] = '{0, 0};
  int prdy_low_tot [2] = '{0, 0};
  int prdy_fall_cyc [2] = '{0, 0};
  logic prdy_prev [2] = '{1'b1, 1'b1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_chk(input string name, input int k, input logic [7:0] act, input bit is_out);
    logic [7:0] e;
    int sz;
    if (is_out) sz = (k == 0) ? exp_out_q0.size() : exp_out_q1.size();
    else        sz = (k == 0) ? exp_in_q0.size()  : exp_in_q1.size();
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected strobe on inst %0d, data %0h (cycle %0d)", name, k, act, cyc);
    end else begin
      if (is_out) e = (k == 0) ? exp_out_q0.pop_front() : exp_out_q1.pop_front();
      else        e = (k == 0) ? exp_in_q0.pop_front()  : exp_in_q1.pop_front();
      chk(name, {24'h0, act}, {24'h0, e});
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        if (out_stb[k]) begin
          pop_chk("wr_data", k, pod[k], 1'b1);
          last_wr_cyc[k] = cyc;
        end
        if (in_stb[k]) pop_chk("rd_data", k, di[k], 1'b0);
        if (di_oe[k]) chk("di_stable", {24'h0, di[k]}, {24'h0, exp_di});
        if (!prdy[k]) begin
          prdy_low_tot[k]++;
          if (prdy_prev[k]) prdy_fall_cyc[k] = cyc;
        end
        prdy_prev[k] = prdy[k];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_cycle(input logic [7:0] addr, input logic sout, input logic sinp);
    @(negedge clk);
    s100_adr   = {8'($urandom_range(0, 255)), addr};
    s100_sOUT  = sout;
    s100_sINP  = sinp;
    s100_pSYNC = 1'b1;
    tick(2);
    s100_pSYNC = 1'b0;
    tick(2);
  endtask

  task automatic bus_out(input logic [7:0] addr, input logic [7:0] data,
                         input logic sout, input logic sinp, input bit do_wr);
    bit hit;
    int fall_cyc, p0, p1;
    s100_DO = data;
    start_cycle(addr, sout, sinp);
    if (!do_wr) return;
    hit = (addr == PORT) && sout && !sinp;
    if (hit) begin
      exp_out_q0.push_back(data);
      exp_out_q1.push_back(data);
      model_out = data;
    end
    p0 = prdy_low_tot[0];
    p1 = prdy_low_tot[1];
    fall_cyc = cyc;
    s100_n_pWR = 1'b0;
    tick(12);
    s100_n_pWR = 1'b1;
    tick(8);
    if (hit) begin
      chk("wr_lat0", last_wr_cyc[0] - fall_cyc, 5);
      chk("wr_lat1", last_wr_cyc[1] - fall_cyc, 5 + W1);
    end
    chk("wr_prdy0", prdy_low_tot[0] - p0, 0);
    chk("wr_prdy1", prdy_low_tot[1] - p1, hit ? W1 : 0);
    chk("wr_pod0", {24'h0, pod[0]}, {24'h0, model_out});
    chk("wr_pod1", {24'h0, pod[1]}, {24'h0, model_out});
    chk("wr_oe0", {31'h0, di_oe[0]}, 0);
    chk("wr_oe1", {31'h0, di_oe[1]}, 0);
    s100_sOUT = 1'b0;
    s100_sINP = 1'b0;
    s100_DO   = 8'($urandom_range(0, 255));
  endtask

  task automatic bus_in(input logic [7:0] addr, input logic [7:0] data,
                        input logic sout, input logic sinp);
    bit hit;
    int rise_cyc, p0, p1;
    port_in_data = data;
    start_cycle(addr, sout, sinp);
    hit = (addr == PORT) && sinp && !sout;
    exp_di = data;
    if (hit) begin
      exp_in_q0.push_back(data);
      exp_in_q1.push_back(data);
    end
    p0 = prdy_low_tot[0];
    p1 = prdy_low_tot[1];
    rise_cyc = cyc;
    s100_pDBIN = 1'b1;
    tick(5);
    port_in_data = ~data;
    tick(5);
    chk("rd_oe0", {31'h0, di_oe[0]}, {31'h0, hit});
    chk("rd_oe1", {31'h0, di_oe[1]}, {31'h0, hit});
    if (hit) chk("rd_di1", {24'h0, di[1]}, {24'h0, data});
    s100_pDBIN = 1'b0;
    tick(8);
    chk("rd_end_oe0", {31'h0, di_oe[0]}, 0);
    chk("rd_end_oe1", {31'h0, di_oe[1]}, 0);
    chk("rd_prdy0", prdy_low_tot[0] - p0, 0);
    chk("rd_prdy1", prdy_low_tot[1] - p1, hit ? W1 : 0);
    if (hit) chk("rd_prdy_start", prdy_fall_cyc[1] - rise_cyc, 4);
    chk("rd_pod0", {24'h0, pod[0]}, {24'h0, model_out});
    s100_sOUT = 1'b0;
    s100_sINP = 1'b0;
    port_in_data = 8'($urandom_range(0, 255));
  endtask

  task automatic reset_during_read();
    port_in_data = 8'h5A;
    start_cycle(PORT, 1'b0, 1'b1);
    exp_di = 8'h5A;
    s100_pDBIN = 1'b1;
    tick(10);
    reset = 1'b1;
    tick(1);
    model_out = 8'h00;
    for (int k = 0; k < 2; k++) begin
      chk("rst_oe", {31'h0, di_oe[k]}, 0);
      chk("rst_prdy", {31'h0, prdy[k]}, 1);
      chk("rst_di", {24'h0, di[k]}, 0);
      chk("rst_pod", {24'h0, pod[k]}, 0);
      chk("rst_state", {29'h0, dbg[k]}, 0);
    end
    reset = 1'b0;
    tick(3);
    s100_pDBIN = 1'b0;
    tick(10);
    s100_sINP = 1'b0;
  endtask

  initial begin
    logic [7:0] a, d;
    logic so, si;
    int r;
    tick(3);
    reset = 1'b0;
    // Idle bus after reset: nothing must move for 100 clocks.
    for (int i = 0; i < 100; i++) begin
      tick(1);
      for (int k = 0; k < 2; k++) begin
        chk("idle_oe", {31'h0, di_oe[k]}, 0);
        chk("idle_prdy", {31'h0, prdy[k]}, 1);
        chk("idle_pod", {24'h0, pod[k]}, 0);
        chk("idle_stb", {30'h0, out_stb[k], in_stb[k]}, 0);
      end
    end

    bus_out(8'h01, 8'hA5, 1'b1, 1'b0, 1'b1);
    bus_out(8'h02, 8'h77, 1'b1, 1'b0, 1'b1);
    bus_out(8'h01, 8'h66, 1'b1, 1'b1, 1'b1);
    bus_in (8'h01, 8'h3C, 1'b0, 1'b1);
    bus_out(8'h01, 8'h99, 1'b1, 1'b0, 1'b0);   // armed, then aborted
    bus_in (8'h01, 8'hC3, 1'b0, 1'b1);
    reset_during_read();
    bus_out(8'h01, 8'h42, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 3);
      a = (r < 2) ? PORT : (r == 2) ? 8'h02 : 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 5);
      so = (r < 2) || (r == 4);
      si = (r == 2) || (r == 3) || (r == 4);
      if (r < 2)       bus_out(a, d, so, si, 1'b1);
      else if (r < 4)  bus_in(a, d, so, si);
      else if ($urandom_range(0, 1) == 1) bus_out(a, d, so, si, 1'b1);
      else             bus_in(a, d, so, si);
    end

    tick(10);
    chk("q_out0_empty", exp_out_q0.size(), 0);
    chk("q_out1_empty", exp_out_q1.size(), 0);
    chk("q_in0_empty", exp_in_q0.size(), 0);
    chk("q_in1_empty", exp_in_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
